// File: rtl/max7219_rx.sv
// MAX7219 cascade receiver: decodes the SPI/LOAD stream sent to a chain of
// MAX7219 devices and mirrors each device's register file on the outputs.
module max7219_rx #(
    parameter int unsigned CHAIN = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sck,
    input  logic                  mosi,
    input  logic                  cs,
    output logic [64*CHAIN-1:0]   pixels,
    output logic [8*CHAIN-1:0]    decode,
    output logic [4*CHAIN-1:0]    intensity,
    output logic [3*CHAIN-1:0]    scan_limit,
    output logic [CHAIN-1:0]      shutdown_n,
    output logic [CHAIN-1:0]      test,
    output logic                  frame_done,
    output logic                  frame_err
);

    localparam int unsigned FRAME_BITS = 16 * CHAIN;
    localparam int unsigned CNT_MAX    = FRAME_BITS + 1;
    localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LATCH = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic sck_meta, sck_sync, sck_prev;
    logic mosi_meta, mosi_sync;
    logic cs_meta, cs_sync, cs_prev;

    logic sck_rise_c;
    logic cs_fall_c;
    logic cs_rise_c;

    logic clr_cnt_c;
    logic shift_en_c;
    logic latch_ok_c;
    logic latch_err_c;

    logic [FRAME_BITS-1:0] shreg;
    logic [CNT_W-1:0]      bit_cnt;

    logic [64*CHAIN-1:0] pixels_nxt;
    logic [8*CHAIN-1:0]  decode_nxt;
    logic [4*CHAIN-1:0]  intensity_nxt;
    logic [3*CHAIN-1:0]  scan_limit_nxt;
    logic [CHAIN-1:0]    shutdown_n_nxt;
    logic [CHAIN-1:0]    test_nxt;
    logic [3:0]          addr;
    logic [7:0]          data;

    // Two-flop synchronizers plus a delayed copy for edge detection; idle
    // levels (cs high, sck low) are restored by reset so no false edge appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            sck_meta  <= 1'b0;
            sck_sync  <= 1'b0;
            sck_prev  <= 1'b0;
            mosi_meta <= 1'b0;
            mosi_sync <= 1'b0;
            cs_meta   <= 1'b1;
            cs_sync   <= 1'b1;
            cs_prev   <= 1'b1;
        end else begin
            sck_meta  <= sck;
            sck_sync  <= sck_meta;
            sck_prev  <= sck_sync;
            mosi_meta <= mosi;
            mosi_sync <= mosi_meta;
            cs_meta   <= cs;
            cs_sync   <= cs_meta;
            cs_prev   <= cs_sync;
        end
    end

    // Edge strobes on the synchronized domain.
    assign sck_rise_c = sck_sync & ~sck_prev;
    assign cs_fall_c  = ~cs_sync & cs_prev;
    assign cs_rise_c  = cs_sync & ~cs_prev;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state and control strobes.
    always_comb begin
        state_nxt   = state;
        clr_cnt_c   = 1'b0;
        shift_en_c  = 1'b0;
        latch_ok_c  = 1'b0;
        latch_err_c = 1'b0;
        case (state)
            S_IDLE: begin
                if (cs_fall_c) begin
                    state_nxt = S_SHIFT;
                    clr_cnt_c = 1'b1;
                end
            end
            S_SHIFT: begin
                shift_en_c = sck_rise_c;
                if (cs_rise_c) begin
                    state_nxt = S_LATCH;
                end
            end
            S_LATCH: begin
                latch_ok_c  = (bit_cnt == CNT_W'(FRAME_BITS));
                latch_err_c = (bit_cnt != '0) && (bit_cnt != CNT_W'(FRAME_BITS));
                // A new frame may already be starting while we latch.
                if (cs_fall_c) begin
                    state_nxt = S_SHIFT;
                    clr_cnt_c = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Shift register and saturating bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else begin
            if (clr_cnt_c) begin
                bit_cnt <= '0;
            end else if (shift_en_c && (bit_cnt != CNT_W'(CNT_MAX))) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end
            if (shift_en_c) begin
                shreg <= FRAME_BITS'({shreg, mosi_sync});
            end
        end
    end

    // Word decode: word k of the shift register targets device k.
    always_comb begin
        pixels_nxt     = pixels;
        decode_nxt     = decode;
        intensity_nxt  = intensity;
        scan_limit_nxt = scan_limit;
        shutdown_n_nxt = shutdown_n;
        test_nxt       = test;
        addr           = 4'h0;
        data           = 8'h00;
        if (latch_ok_c) begin
            for (int unsigned k = 0; k < CHAIN; k++) begin
                addr = shreg[k*16 + 8 +: 4];
                data = shreg[k*16 +: 8];
                case (addr)
                    4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                        pixels_nxt[k*64 + (32'(addr) - 32'd1)*32'd8 +: 8] = data;
                    end
                    4'h9: decode_nxt[k*8 +: 8]     = data;
                    4'hA: intensity_nxt[k*4 +: 4]  = data[3:0];
                    4'hB: scan_limit_nxt[k*3 +: 3] = data[2:0];
                    4'hC: shutdown_n_nxt[k]        = data[0];
                    4'hF: test_nxt[k]              = data[0];
                    default: begin
                    end
                endcase
            end
        end
    end

    // Registered outputs and one-cycle frame pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            pixels     <= '0;
            decode     <= '0;
            intensity  <= '0;
            scan_limit <= '0;
            shutdown_n <= '0;
            test       <= '0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            pixels     <= pixels_nxt;
            decode     <= decode_nxt;
            intensity  <= intensity_nxt;
            scan_limit <= scan_limit_nxt;
            shutdown_n <= shutdown_n_nxt;
            test       <= test_nxt;
            frame_done <= latch_ok_c;
            frame_err  <= latch_err_c;
        end
    end

endmodule

// File: tb/tb_max7219_rx.sv
// Directed bench for max7219_rx with a register-file model of the device chain.
module tb_max7219_rx;

    localparam int unsigned CHAIN = 2;
    localparam int unsigned PH    = 4;

    logic                clk;
    logic                rst;
    logic                sck;
    logic                mosi;
    logic                cs;
    logic [64*CHAIN-1:0] pixels;
    logic [8*CHAIN-1:0]  decode;
    logic [4*CHAIN-1:0]  intensity;
    logic [3*CHAIN-1:0]  scan_limit;
    logic [CHAIN-1:0]    shutdown_n;
    logic [CHAIN-1:0]    test;
    logic                frame_done;
    logic                frame_err;

    max7219_rx #(.CHAIN(CHAIN)) dut (
        .clk        (clk),
        .rst        (rst),
        .sck        (sck),
        .mosi       (mosi),
        .cs         (cs),
        .pixels     (pixels),
        .decode     (decode),
        .intensity  (intensity),
        .scan_limit (scan_limit),
        .shutdown_n (shutdown_n),
        .test       (test),
        .frame_done (frame_done),
        .frame_err  (frame_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int commit_cyc = -1;
    int done_cyc = -1;
    int err_cyc = -1;
    bit check_en = 1'b0;
    logic bits[$];

    // Model: pending (nx) and visible (vis) register files per device.
    logic [7:0] nx_dig  [CHAIN][8];
    logic [7:0] nx_dec  [CHAIN];
    logic [3:0] nx_int  [CHAIN];
    logic [2:0] nx_scan [CHAIN];
    logic       nx_shdn [CHAIN];
    logic       nx_test [CHAIN];
    logic [7:0] vis_dig  [CHAIN][8];
    logic [7:0] vis_dec  [CHAIN];
    logic [3:0] vis_int  [CHAIN];
    logic [2:0] vis_scan [CHAIN];
    logic       vis_shdn [CHAIN];
    logic       vis_test [CHAIN];

    logic [64*CHAIN-1:0] exp_pix;
    logic [8*CHAIN-1:0]  exp_dec;
    logic [4*CHAIN-1:0]  exp_int;
    logic [3*CHAIN-1:0]  exp_scan;
    logic [CHAIN-1:0]    exp_shdn;
    logic [CHAIN-1:0]    exp_test;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < CHAIN; d++) begin
            for (int r = 0; r < 8; r++) begin
                nx_dig[d][r]  = 8'h00;
                vis_dig[d][r] = 8'h00;
            end
            nx_dec[d]  = 8'h00; vis_dec[d]  = 8'h00;
            nx_int[d]  = 4'h0;  vis_int[d]  = 4'h0;
            nx_scan[d] = 3'h0;  vis_scan[d] = 3'h0;
            nx_shdn[d] = 1'b0;  vis_shdn[d] = 1'b0;
            nx_test[d] = 1'b0;  vis_test[d] = 1'b0;
        end
        commit_cyc = -1;
        done_cyc   = -1;
        err_cyc    = -1;
        bits.delete();
    endtask

    task automatic model_apply(input int dev, input logic [15:0] w);
        int a;
        a = int'(w[11:8]);
        if (a >= 1 && a <= 8) nx_dig[dev][a-1] = w[7:0];
        else if (a == 9)  nx_dec[dev]  = w[7:0];
        else if (a == 10) nx_int[dev]  = w[3:0];
        else if (a == 11) nx_scan[dev] = w[2:0];
        else if (a == 12) nx_shdn[dev] = w[0];
        else if (a == 15) nx_test[dev] = w[0];
    endtask

    // Cycle counter; the model's registers become visible four edges after cs rises.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (cyc == commit_cyc) begin
            vis_dig  = nx_dig;
            vis_dec  = nx_dec;
            vis_int  = nx_int;
            vis_scan = nx_scan;
            vis_shdn = nx_shdn;
            vis_test = nx_test;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (check_en) begin
            for (int d = 0; d < CHAIN; d++) begin
                for (int r = 0; r < 8; r++) exp_pix[d*64 + r*8 +: 8] = vis_dig[d][r];
                exp_dec[d*8 +: 8]  = vis_dec[d];
                exp_int[d*4 +: 4]  = vis_int[d];
                exp_scan[d*3 +: 3] = vis_scan[d];
                exp_shdn[d]        = vis_shdn[d];
                exp_test[d]        = vis_test[d];
            end
            chk("pixels", pixels, exp_pix);
            chk("decode", decode, exp_dec);
            chk("intensity", intensity, exp_int);
            chk("scan_limit", scan_limit, exp_scan);
            chk("shutdown_n", shutdown_n, exp_shdn);
            chk("test", test, exp_test);
            chk("frame_done", frame_done, (cyc == done_cyc));
            chk("frame_err", frame_err, (cyc == err_cyc));
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(posedge clk); #1; mosi = b;
        repeat (PH-1) @(posedge clk);
        #1; sck = 1'b1;
        repeat (PH) @(posedge clk);
        #1; sck = 1'b0;
        if (cs == 1'b0) bits.push_back(b);
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic cs_low();
        @(posedge clk); #1; cs = 1'b0;
        bits.delete();
        repeat (PH) @(posedge clk);
    endtask

    // Raise cs and predict the outcome of the frame from the bits sent.
    task automatic cs_high(output int c0);
        logic [15:0] w;
        @(posedge clk); #1; cs = 1'b1;
        c0 = cyc;
        if (bits.size() == 16*CHAIN) begin
            for (int j = 0; j < CHAIN; j++) begin
                for (int b = 0; b < 16; b++) w[15-b] = bits[16*j + b];
                model_apply(CHAIN-1-j, w);
            end
            commit_cyc = c0 + 4;
            done_cyc   = c0 + 4;
        end else if (bits.size() != 0) begin
            err_cyc = c0 + 4;
        end
        bits.delete();
    endtask

    // Literal latency check: the pulse must appear exactly four edges after cs rises.
    task automatic expect_pulse_at(input string name, input int c0, input bit want_err);
        int found;
        found = -1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (((want_err ? frame_err : frame_done) === 1'b1) && (found < 0)) found = cyc;
        end
        chk(name, 128'(found), 128'(c0 + 4));
    endtask

    task automatic do_reset(input bit raise_cs);
        @(posedge clk); #1; rst = 1'b1;
        if (raise_cs) cs = 1'b1;
        @(posedge clk); #1;
        model_reset();
        check_en = 1'b1;
        repeat (2) @(posedge clk);
        #1; rst = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int c0;
        int c1;
        rst = 1'b1; cs = 1'b1; sck = 1'b0; mosi = 1'b0;

        // Reset state.
        do_reset(1'b0);
        idle(2);
        chk("rst_pixels", pixels, '0);
        chk("rst_shutdown_n", shutdown_n, '0);
        chk("rst_pulses", {frame_done, frame_err}, 2'b00);

        // sck with cs high is ignored; empty cs window gives no pulse.
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        cs_low();
        idle(6);
        cs_high(c0);
        idle(10);
        chk("empty_pixels", pixels, '0);

        // Digit writes to both devices.
        cs_low();
        send_word(16'h0155); send_word(16'h0233);
        cs_high(c0);
        expect_pulse_at("lat_digits", c0, 1'b0);
        chk("dev1_dig1", pixels[71:64], 8'h55);
        chk("dev0_dig2", pixels[15:8], 8'h33);

        // Intensity on device 1, shutdown on device 0.
        cs_low();
        send_word(16'h0A0F); send_word(16'h0C01);
        cs_high(c0);
        expect_pulse_at("lat_ctrl", c0, 1'b0);
        chk("intensity_f0", intensity, 8'hF0);
        chk("shutdown_01", shutdown_n, 2'b01);

        // 31 bits: frame discarded.
        cs_low();
        send_word(16'h0B07);
        for (int i = 14; i >= 0; i--) send_bit(1'(16'h0977 >> i));
        cs_high(c0);
        expect_pulse_at("err_31", c0, 1'b1);
        chk("err31_intensity", intensity, 8'hF0);
        chk("err31_scan", scan_limit, 6'o00);

        // No-op word to device 1, test mode on device 0.
        cs_low();
        send_word(16'h0000); send_word(16'h0F01);
        cs_high(c0);
        expect_pulse_at("lat_test", c0, 1'b0);
        chk("test_01", test, 2'b01);
        chk("noop_intensity", intensity, 8'hF0);

        // Upper nibble ignored: decode on device 1, scan limit on device 0.
        cs_low();
        send_word(16'h39AA); send_word(16'hFB05);
        cs_high(c0);
        idle(8);
        chk("decode_aa00", decode, 16'hAA00);
        chk("scan_05", scan_limit, 6'b000101);

        // Addresses 0xD/0xE are no-ops.
        cs_low();
        send_word(16'h0D12); send_word(16'h0E34);
        cs_high(c0);
        expect_pulse_at("lat_noop", c0, 1'b0);
        chk("noop_decode", decode, 16'hAA00);

        // 40 bits: counter saturates, frame discarded.
        cs_low();
        send_word(16'h0177); send_word(16'h0288);
        for (int i = 0; i < 8; i++) send_bit(1'b1);
        cs_high(c0);
        expect_pulse_at("err_40", c0, 1'b1);
        chk("err40_dig", pixels[71:64], 8'h55);

        // 33 bits: frame discarded.
        cs_low();
        send_word(16'h0366); send_word(16'h0499); send_bit(1'b0);
        cs_high(c0);
        idle(8);

        // Back-to-back frames: cs falls again during the latch cycle.
        cs_low();
        send_word(16'h0411); send_word(16'h0522);
        cs_high(c0);
        cs_low();
        send_word(16'h0633); send_word(16'h0744);
        cs_high(c1);
        expect_pulse_at("lat_b2b", c1, 1'b0);
        chk("b2b_dev1_dig4", pixels[95:88], 8'h11);
        chk("b2b_dev0_dig5", pixels[39:32], 8'h22);
        chk("b2b_dev1_dig6", pixels[111:104], 8'h33);
        chk("b2b_dev0_dig7", pixels[55:48], 8'h44);

        // Reset mid-frame, then a complete frame.
        cs_low();
        send_word(16'h0123);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        do_reset(1'b1);
        idle(4);
        chk("midrst_pixels", pixels, '0);
        chk("midrst_intensity", intensity, '0);
        cs_low();
        send_word(16'h08AA); send_word(16'h08BB);
        cs_high(c0);
        expect_pulse_at("lat_after_rst", c0, 1'b0);
        chk("dev1_dig8", pixels[127:120], 8'hAA);
        chk("dev0_dig8", pixels[63:56], 8'hBB);

        // Shutdown bit per device.
        cs_low();
        send_word(16'h0C01); send_word(16'h0C00);
        cs_high(c0);
        idle(8);
        chk("shutdown_10", shutdown_n, 2'b10);

        idle(4);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/max7219_rx.md
MAX7219_RX -- requirements
Module: max7219_rx

Interface
REQ-001 Parameter CHAIN, default 2: number of cascaded MAX7219 devices modelled.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 sck  input  1  SPI clock from the display driver, asynchronous to clk.
REQ-005 mosi  input  1  SPI data, MSB first, sampled on sck rising edge.
REQ-006 cs  input  1  chip select/LOAD, active-low; a rising edge latches the frame.
REQ-007 pixels  output  64*CHAIN  digit registers; device d, digit r (1..8) at bits [d*64+(r-1)*8 +: 8].
REQ-008 decode  output  8*CHAIN  decode-mode register per device, device d at [d*8 +: 8].
REQ-009 intensity  output  4*CHAIN  intensity register per device, device d at [d*4 +: 4].
REQ-010 scan_limit  output  3*CHAIN  scan-limit register per device, device d at [d*3 +: 3].
REQ-011 shutdown_n  output  CHAIN  shutdown register bit0 per device; 0 = shutdown.
REQ-012 test  output  CHAIN  display-test register bit0 per device.
REQ-013 frame_done  output  1  one-cycle pulse when a valid frame is latched.
REQ-014 frame_err  output  1  one-cycle pulse when a frame with the wrong bit count is discarded.

Function
REQ-015 sck, mosi and cs SHALL each pass through a 2-flop synchronizer; edges are detected on the synchronized signals against a 1-cycle delayed copy.
REQ-016 The block SHALL require sck high and low phases of at least 3 clk periods; shorter phases are outside specification.
REQ-017 Synchronized cs falling edge SHALL clear the bit counter and enter state SHIFT from IDLE.
REQ-018 In SHIFT, each synchronized sck rising edge SHALL shift synchronized mosi into the LSB of a 16*CHAIN-bit shift register and increment the bit counter.
REQ-019 The bit counter SHALL saturate at 16*CHAIN+1; further sck edges keep shifting but do not wrap the counter.
REQ-020 sck edges while cs is high (IDLE) SHALL be ignored.
REQ-021 On synchronized cs rising edge the FSM SHALL go to LATCH for exactly one cycle, then IDLE.
REQ-022 In LATCH with count == 16*CHAIN: word k (bits [k*16 +: 16] of the shift register) SHALL be applied to device k, so the first word sent reaches device CHAIN-1; frame_done pulses.
REQ-023 In LATCH with 0 < count != 16*CHAIN: no register SHALL change; frame_err pulses.
REQ-024 In LATCH with count == 0: no register change, neither pulse asserted.
REQ-025 Word decode: bits [11:8] address, [7:0] data; address 0x0 no-op; 0x1-0x8 digit r; 0x9 decode; 0xA intensity = data[3:0]; 0xB scan_limit = data[2:0]; 0xC shutdown_n = data[0]; 0xF test = data[0]; 0xD, 0xE no-op; bits [15:12] ignored.
REQ-026 Latency: outputs and pulse SHALL update on the 4th clk rising edge after the first edge that samples raw cs high (2 sync + 1 detect + 1 latch).
REQ-027 A cs falling edge detected in the LATCH cycle SHALL be honoured: the block SHALL enter SHIFT with counter 0 on the following cycle.

Reset
REQ-028 When rst is high at a clk edge: FSM = IDLE, counter = 0, shift register = 0, synchronizers cleared to cs = 1, sck = 0, mosi = 0.
REQ-029 Reset values: pixels = 0, decode = 0, intensity = 0, scan_limit = 0, shutdown_n = 0, test = 0, frame_done = 0, frame_err = 0.
REQ-030 Reset mid-frame SHALL abandon the partial frame with no pulse; a frame requires a fresh cs falling edge after rst deasserts.

Verification (CHAIN = 2)
REQ-031 Send 0x0155 then 0x0233 in one cs window -> pixels[71:64] = 0x55, pixels[15:8] = 0x33, frame_done one pulse, all else 0.
REQ-032 Send 0x0A0F,0x0C01 (dev1 intensity, dev0 shutdown) -> intensity = 8'hF0, shutdown_n = 2'b01, frame_done at cs-high + 4 edges.
REQ-033 Send 31 bits then raise cs -> frame_err one pulse, all registers unchanged from prior value.
REQ-034 Send 0x0000, 0x0F01 -> test = 2'b01, device 1 registers unchanged (no-op).
REQ-035 Assert rst after 20 bits of a frame, deassert, send full frame 0x08AA,0x08BB -> pixels[127:120] = 0xAA, pixels[63:56] = 0xBB, no frame_err.
REQ-036 cs low then high with no sck edges -> no pulses, no register change.
